// File: rtl/pool_result_packer_pkg.sv
// Shared pooling definitions: result width, default lane count, packer state
// encoding and a small helper for lane-occupancy arithmetic.
package pool_result_packer_pkg;

    localparam int POOL_LANES = 32;
    localparam int RES_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_e;

    // Free lanes left in a buffer given its write pointer; a full buffer has none.
    function automatic int unsigned lanes_free(input int unsigned ptr,
                                               input int unsigned lanes,
                                               input logic        full);
        return full ? 32'd0 : (lanes - ptr);
    endfunction

endpackage

// File: rtl/pool_result_packer_if.sv
// Job control, pooled-result input stream and packed-word output stream of the
// pooling result packer. The packer uses the slave modport.
interface pool_result_packer_if
    import pool_result_packer_pkg::*;
#(
    parameter int POOLING_UNITS = 3,
    parameter int LANES         = POOL_LANES,
    parameter int LIN_WIDTH     = 10,
    parameter int ADDR_WIDTH    = 5
);
    logic                                 start;
    logic [ADDR_WIDTH-1:0]                base_addr;
    logic [LIN_WIDTH-1:0]                 total_results;
    logic [POOLING_UNITS-1:0][RES_W-1:0]  din;
    logic [POOLING_UNITS-1:0]             din_valid;
    logic                                 in_ready;
    logic [LANES-1:0][RES_W-1:0]          dout;
    logic [LANES-1:0]                     dout_lane_en;
    logic [ADDR_WIDTH-1:0]                dout_addr;
    logic                                 dout_valid;
    logic                                 dout_ready;
    logic                                 done;
    logic                                 overflow;

    modport master (
        output start, base_addr, total_results, din, din_valid, dout_ready,
        input  in_ready, dout, dout_lane_en, dout_addr, dout_valid, done, overflow
    );

    modport slave (
        input  start, base_addr, total_results, din, din_valid, dout_ready,
        output in_ready, dout, dout_lane_en, dout_addr, dout_valid, done, overflow
    );
endinterface

// File: rtl/pool_result_packer_word_buffer.sv
// One LANES-wide packing buffer: per-lane data and written flag plus a full
// flag. Freeing clears the contents so unwritten lanes of a later partial word
// read zero; writes in the same cycle as a free take priority over the clear.
module pool_word_buffer
    import pool_result_packer_pkg::*;
#(
    parameter int LANES = POOL_LANES
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic                        clear,
    input  logic                        free,
    input  logic                        set_full,
    input  logic [LANES-1:0]            wr_en,
    input  logic [LANES-1:0][RES_W-1:0] wr_data,
    output logic [LANES-1:0][RES_W-1:0] data,
    output logic [LANES-1:0]            lane_mask,
    output logic                        full
);
    logic full_q;
    logic full_d;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [RES_W-1:0] lane_q;
        logic [RES_W-1:0] lane_d;
        logic             written_q;
        logic             written_d;

        // Lane update: clear on free/job start, then overlay any new write.
        always_comb begin
            lane_d    = lane_q;
            written_d = written_q;
            if (clear || free) begin
                lane_d    = '0;
                written_d = 1'b0;
            end
            if (wr_en[gi]) begin
                lane_d    = wr_data[gi];
                written_d = 1'b1;
            end
        end

        // Lane storage.
        always_ff @(posedge clk or posedge res) begin
            if (res) begin
                lane_q    <= '0;
                written_q <= 1'b0;
            end else begin
                lane_q    <= lane_d;
                written_q <= written_d;
            end
        end

        assign data[gi]      = lane_q;
        assign lane_mask[gi] = written_q;
    end

    // Full flag: cleared when the word is taken, set when packing completes it.
    always_comb begin
        full_d = full_q;
        if (clear || free) begin
            full_d = 1'b0;
        end
        if (set_full) begin
            full_d = 1'b1;
        end
    end

    // Full flag register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    assign full = full_q;

endmodule

// File: rtl/pool_result_packer.sv
// Packs per-unit pooled results into LANES-wide words using two ping-pong
// buffers. Results land in consecutive lanes in arrival order; a batch that
// crosses the end of a word spills into the other buffer. Completed words are
// emitted oldest first at base_addr + words emitted.
module pool_result_packer
    import pool_result_packer_pkg::*;
#(
    parameter int POOLING_UNITS = 3,
    parameter int LANES         = POOL_LANES,
    parameter int LIN_WIDTH     = 10,
    parameter int ADDR_WIDTH    = 5
) (
    input  logic                clk,
    input  logic                res,
    pool_result_packer_if.slave bus
);
    localparam int PTR_W = $clog2(LANES);

    pack_state_e            state_q, state_d;
    logic                   fill_sel_q, fill_sel_d;
    logic                   out_sel_q, out_sel_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [LIN_WIDTH-1:0]   accepted_q, accepted_d;
    logic [LIN_WIDTH-1:0]   total_q, total_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ADDR_WIDTH-1:0]  words_q, words_d;
    logic                   overflow_q, overflow_d;

    logic [1:0][LANES-1:0]            wr_en;
    logic [1:0][LANES-1:0][RES_W-1:0] wr_data;
    logic [1:0][LANES-1:0][RES_W-1:0] buf_data;
    logic [1:0][LANES-1:0]            buf_mask;
    logic [1:0]                       buf_full;
    logic [1:0]                       set_full;
    logic [1:0]                       free;
    logic                             clear;

    int unsigned            fill_free;
    int unsigned            cnt;
    int unsigned            pos;
    int unsigned            remaining;
    int unsigned            new_ptr;
    logic [PTR_W-1:0]       lane_sel;
    logic                   bank_sel;
    logic [PTR_W-1:0]       ptr_next;
    logic [LIN_WIDTH-1:0]   acc_cnt;
    logic                   in_ready_c;
    logic                   drop;
    logic                   wrap;
    logic                   last;
    logic                   xfer;

    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        pool_word_buffer #(
            .LANES(LANES)
        ) u_buf (
            .clk       (clk),
            .res       (res),
            .clear     (clear),
            .free      (free[gi]),
            .set_full  (set_full[gi]),
            .wr_en     (wr_en[gi]),
            .wr_data   (wr_data[gi]),
            .data      (buf_data[gi]),
            .lane_mask (buf_mask[gi]),
            .full      (buf_full[gi])
        );
    end

    // A whole batch is guaranteed room: either it fits in the fill buffer or
    // the other buffer is empty and can take the spill.
    assign fill_free  = lanes_free(32'(ptr_q), 32'(LANES), buf_full[fill_sel_q]);
    assign in_ready_c = (state_q == ST_PACK) &&
                        ((fill_free >= 32'(POOLING_UNITS)) || !buf_full[~fill_sel_q]);

    // Lane routing: accept valid results lowest unit first, up to the job
    // remainder, and place them at consecutive lanes across the buffer seam.
    always_comb begin
        wr_en     = '0;
        wr_data   = '0;
        set_full  = '0;
        drop      = 1'b0;
        cnt       = 0;
        pos       = 0;
        lane_sel  = '0;
        bank_sel  = 1'b0;
        remaining = 32'(total_q - accepted_q);
        for (int u = 0; u < POOLING_UNITS; u++) begin
            if (bus.din_valid[u]) begin
                if (in_ready_c && (cnt < remaining)) begin
                    pos      = 32'(ptr_q) + cnt;
                    lane_sel = PTR_W'((pos >= LANES) ? (pos - LANES) : pos);
                    bank_sel = fill_sel_q ^ (pos >= LANES);
                    wr_en[bank_sel][lane_sel]   = 1'b1;
                    wr_data[bank_sel][lane_sel] = bus.din[u];
                    cnt = cnt + 1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        new_ptr  = 32'(ptr_q) + cnt;
        wrap     = (new_ptr >= LANES);
        ptr_next = PTR_W'(wrap ? (new_ptr - LANES) : new_ptr);
        acc_cnt  = LIN_WIDTH'(cnt);
        last     = (state_q == ST_PACK) && ((accepted_q + acc_cnt) == total_q);
        if (wrap) begin
            set_full[fill_sel_q] = 1'b1;
        end
        // Close out a partially written final word.
        if (last && (ptr_next != '0)) begin
            set_full[fill_sel_q ^ wrap] = 1'b1;
        end
    end

    // Next-state, job counters and output-side word hand-off.
    always_comb begin
        state_d    = state_q;
        fill_sel_d = fill_sel_q;
        out_sel_d  = out_sel_q;
        ptr_d      = ptr_q;
        accepted_d = accepted_q;
        total_d    = total_q;
        base_d     = base_q;
        words_d    = words_q;
        overflow_d = overflow_q | drop;
        free       = '0;
        clear      = 1'b0;
        xfer       = buf_full[out_sel_q] && bus.dout_ready;

        if (xfer) begin
            free[out_sel_q] = 1'b1;
            out_sel_d       = ~out_sel_q;
            words_d         = words_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    clear      = 1'b1;
                    fill_sel_d = 1'b0;
                    out_sel_d  = 1'b0;
                    ptr_d      = '0;
                    accepted_d = '0;
                    words_d    = '0;
                    overflow_d = 1'b0;
                    base_d     = bus.base_addr;
                    total_d    = bus.total_results;
                    state_d    = (bus.total_results == '0) ? ST_DONE : ST_PACK;
                end
            end
            ST_PACK: begin
                accepted_d = accepted_q + acc_cnt;
                ptr_d      = ptr_next;
                if (wrap) begin
                    fill_sel_d = ~fill_sel_q;
                end
                if (last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && !buf_full[~out_sel_q]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and job registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= ST_IDLE;
            fill_sel_q <= 1'b0;
            out_sel_q  <= 1'b0;
            ptr_q      <= '0;
            accepted_q <= '0;
            total_q    <= '0;
            base_q     <= '0;
            words_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_sel_q <= fill_sel_d;
            out_sel_q  <= out_sel_d;
            ptr_q      <= ptr_d;
            accepted_q <= accepted_d;
            total_q    <= total_d;
            base_q     <= base_d;
            words_q    <= words_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.dout_valid   = buf_full[out_sel_q];
    assign bus.dout         = buf_data[out_sel_q];
    assign bus.dout_lane_en = buf_mask[out_sel_q];
    assign bus.dout_addr    = base_q + words_q;
    assign bus.done         = (state_q == ST_DONE);
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_pool_result_packer.sv
// Directed bench for pool_result_packer: a table of jobs with hand-computed
// word counts, final lane masks and addresses, plus a mid-job reset sequence.
module tb_pool_result_packer;
    import pool_result_packer_pkg::*;

    localparam int PU = 3;
    localparam int LN = 32;
    localparam int LW = 10;
    localparam int AW = 5;

    typedef struct {
        int          total;
        int          base;
        logic [2:0]  vmask;
        int          hold;
        bit          inj;
        bit          over;
        int          exp_words;
        logic [31:0] exp_last_en;
        int          exp_last_addr;
        bit          exp_stall;
    } vec_t;

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    pool_result_packer_if #(.POOLING_UNITS(PU), .LANES(LN), .LIN_WIDTH(LW), .ADDR_WIDTH(AW)) pif ();

    pool_result_packer #(
        .POOLING_UNITS(PU),
        .LANES(LN),
        .LIN_WIDTH(LW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (pif)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout_valid"}, 512'(pif.dout_valid), 512'(0));
        chk({tag, "_in_ready"},   512'(pif.in_ready),   512'(0));
        chk({tag, "_done"},       512'(pif.done),       512'(0));
        chk({tag, "_overflow"},   512'(pif.overflow),   512'(0));
        chk({tag, "_dout_addr"},  512'(pif.dout_addr),  512'(0));
        chk({tag, "_lane_en"},    512'(pif.dout_lane_en), 512'(0));
        chk({tag, "_dout"},       512'(pif.dout),       512'(0));
    endtask

    task automatic run_job(input vec_t v, input int vi);
        int          sent;
        int          words;
        int          k;
        int          idx;
        bit          stall;
        bit          inj_done;
        bit          got_done;
        bit          prev_hold;
        logic [511:0] held_dout;
        logic [31:0] held_en;
        logic [AW-1:0] held_addr;
        logic [15:0] seed;
        logic [511:0] exp_d;
        logic [31:0] exp_en;
        logic [AW-1:0] exp_addr;
        sent = 0; words = 0; stall = 0; inj_done = 0; got_done = 0; prev_hold = 0;
        held_dout = '0; held_en = '0; held_addr = '0;
        seed = 16'(vi * 4096);
        for (int cycle = 0; cycle < 3000 && !got_done; cycle++) begin
            @(negedge clk);
            pif.start         = (cycle == 0);
            pif.base_addr     = AW'(v.base);
            pif.total_results = LW'(v.total);
            pif.dout_ready    = (cycle >= v.hold);
            pif.din_valid     = '0;
            pif.din           = '0;
            if (pif.done) got_done = 1;
            if (cycle == 1) chk($sformatf("job%0d_overflow_cleared", vi), 512'(pif.overflow), 512'(0));
            if (prev_hold) begin
                chk($sformatf("job%0d_hold_valid", vi), 512'(pif.dout_valid), 512'(1));
                chk($sformatf("job%0d_hold_dout", vi), pif.dout, held_dout);
                chk($sformatf("job%0d_hold_en", vi), 512'(pif.dout_lane_en), 512'(held_en));
                chk($sformatf("job%0d_hold_addr", vi), 512'(pif.dout_addr), 512'(held_addr));
            end
            if (cycle >= 1 && sent < v.total) begin
                if (pif.in_ready) begin
                    k = 0;
                    for (int u = 0; u < PU; u++) begin
                        if (v.vmask[u] && ((sent + k < v.total) || v.over)) begin
                            pif.din_valid[u] = 1'b1;
                            pif.din[u]       = seed + 16'(sent + k);
                            k++;
                        end
                    end
                    sent = (sent + k > v.total) ? v.total : sent + k;
                end else begin
                    stall = 1;
                    if (v.inj && !inj_done && sent > 0) begin
                        pif.din_valid = 3'b111;
                        for (int u = 0; u < PU; u++) pif.din[u] = 16'hDEAD;
                        inj_done = 1;
                    end
                end
            end
            if (pif.dout_valid && pif.dout_ready) begin
                exp_addr = (words == v.exp_words - 1) ? AW'(v.exp_last_addr) : AW'(v.base + words);
                exp_en   = (words == v.exp_words - 1) ? v.exp_last_en : 32'hFFFF_FFFF;
                for (int i = 0; i < LN; i++) begin
                    idx = words * LN + i;
                    exp_d[i*16 +: 16] = (idx < v.total) ? seed + 16'(idx) : 16'h0000;
                end
                $display("[TB] job %0d word %0d addr=%0d en=%h", vi, words, pif.dout_addr, pif.dout_lane_en);
                chk($sformatf("job%0d_w%0d_addr", vi, words), 512'(pif.dout_addr), 512'(exp_addr));
                chk($sformatf("job%0d_w%0d_en", vi, words), 512'(pif.dout_lane_en), 512'(exp_en));
                chk($sformatf("job%0d_w%0d_data", vi, words), pif.dout, exp_d);
                words++;
            end
            prev_hold = pif.dout_valid && !pif.dout_ready;
            held_dout = pif.dout;
            held_en   = pif.dout_lane_en;
            held_addr = pif.dout_addr;
        end
        chk($sformatf("job%0d_done_seen", vi), 512'(got_done), 512'(1));
        @(negedge clk);
        pif.din_valid = '0;
        chk($sformatf("job%0d_done_one_cycle", vi), 512'(pif.done), 512'(0));
        chk($sformatf("job%0d_idle_valid", vi), 512'(pif.dout_valid), 512'(0));
        chk($sformatf("job%0d_words", vi), 512'(words), 512'(v.exp_words));
        chk($sformatf("job%0d_overflow", vi), 512'(pif.overflow), 512'(v.inj | v.over));
        chk($sformatf("job%0d_stall", vi), 512'(stall), 512'(v.exp_stall));
    endtask

    initial begin
        int vcount;
        pif.start = 1'b0; pif.base_addr = '0; pif.total_results = '0;
        pif.din = '0; pif.din_valid = '0; pif.dout_ready = 1'b0;
        #2 res = 1'b1;
        #1 chk_zero("reset");
        repeat (3) @(negedge clk);
        res = 1'b0;

        vecs[0] = '{total:32, base:4,  vmask:3'b111, hold:0,  inj:0, over:0, exp_words:1, exp_last_en:32'hFFFF_FFFF, exp_last_addr:4,  exp_stall:0};
        vecs[1] = '{total:7,  base:0,  vmask:3'b001, hold:0,  inj:0, over:0, exp_words:1, exp_last_en:32'h0000_007F, exp_last_addr:0,  exp_stall:0};
        vecs[2] = '{total:96, base:10, vmask:3'b111, hold:40, inj:1, over:0, exp_words:3, exp_last_en:32'hFFFF_FFFF, exp_last_addr:12, exp_stall:1};
        vecs[3] = '{total:64, base:31, vmask:3'b111, hold:0,  inj:0, over:0, exp_words:2, exp_last_en:32'hFFFF_FFFF, exp_last_addr:0,  exp_stall:0};
        vecs[4] = '{total:50, base:2,  vmask:3'b101, hold:0,  inj:0, over:0, exp_words:2, exp_last_en:32'h0003_FFFF, exp_last_addr:3,  exp_stall:0};
        vecs[5] = '{total:5,  base:7,  vmask:3'b110, hold:0,  inj:0, over:0, exp_words:1, exp_last_en:32'h0000_001F, exp_last_addr:7,  exp_stall:0};
        vecs[6] = '{total:33, base:0,  vmask:3'b111, hold:0,  inj:0, over:0, exp_words:2, exp_last_en:32'h0000_0001, exp_last_addr:1,  exp_stall:0};
        vecs[7] = '{total:4,  base:20, vmask:3'b111, hold:0,  inj:0, over:1, exp_words:1, exp_last_en:32'h0000_000F, exp_last_addr:20, exp_stall:0};
        vecs[8] = '{total:0,  base:9,  vmask:3'b111, hold:0,  inj:0, over:0, exp_words:0, exp_last_en:32'h0000_0000, exp_last_addr:9,  exp_stall:0};

        for (int i = 0; i < 9; i++) begin
            run_job(vecs[i], i);
        end

        // Mid-job reset with a completed word waiting on a stalled consumer.
        @(negedge clk);
        pif.start = 1'b1; pif.base_addr = AW'(3); pif.total_results = LW'(64); pif.dout_ready = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            pif.start = 1'b0;
            pif.din_valid = pif.in_ready ? 3'b111 : 3'b000;
            for (int u = 0; u < PU; u++) pif.din[u] = 16'(16'h7000 + c * PU + u);
        end
        chk("pre_reset_valid", 512'(pif.dout_valid), 512'(1));
        res = 1'b1;
        #1 chk_zero("mid_reset");
        pif.din_valid = '0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        pif.dout_ready = 1'b1;
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pif.dout_valid) vcount++;
        end
        chk("post_reset_no_valid", 512'(vcount), 512'(0));
        run_job(vecs[0], 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_result_packer.md
POOL_RESULT_PACKER -- requirements
Module: pool_result_packer

Interface
REQ-001 SHALL have parameter POOLING_UNITS, default 3, number of pooling result streams.
REQ-002 SHALL have parameter LANES, default 32, lanes per packed output word.
REQ-003 SHALL have parameter LIN_WIDTH, default 10, result-count width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 5, output word address width.
REQ-005 SHALL have ports: clk  in  1  sole clock; res  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: start  in  1  one-cycle job start; base_addr  in  ADDR_WIDTH  first word address; total_results  in  LIN_WIDTH  results in the job.
REQ-007 SHALL have ports: din  in  POOLING_UNITS x 16  pooled results; din_valid  in  POOLING_UNITS  per-unit valid; in_ready  out  1  packer can take a full POOLING_UNITS batch.
REQ-008 SHALL have ports: dout  out  LANES x 16  packed word; dout_lane_en  out  LANES  written-lane mask; dout_addr  out  ADDR_WIDTH  word address; dout_valid  out  1; dout_ready  in  1.
REQ-009 SHALL have ports: done  out  1  one-cycle job-complete pulse; overflow  out  1  sticky dropped-result flag.

Function
REQ-010 SHALL implement states IDLE, PACK, DRAIN, DONE.
REQ-011 IDLE->PACK on start with total_results != 0, latching base_addr and total_results and clearing counters, lane pointer and overflow; start with total_results == 0 SHALL go IDLE->DONE.
REQ-012 start outside IDLE SHALL be ignored.
REQ-013 SHALL hold two LANES-wide ping-pong buffers, each with a full flag; one is the fill buffer.
REQ-014 In PACK, valid results accepted in a cycle SHALL be written in ascending unit index to consecutive lanes from the lane pointer; pointer advances by the accepted count.
REQ-015 A batch crossing lane LANES-1 SHALL spill remaining results to lane 0 of the other buffer, which becomes the fill buffer; the completed buffer is marked full.
REQ-016 in_ready SHALL be high in PACK when the fill buffer has >= POOLING_UNITS free lanes or the other buffer is empty; low in IDLE, DRAIN, DONE.
REQ-017 din_valid bits asserted while in_ready is low, outside PACK, or beyond the remaining job count SHALL be dropped and set overflow; lowest-index results are accepted first when only part fits.
REQ-018 When accepted count reaches total_results, the partial fill buffer (if any lane written) SHALL be marked full with dout_lane_en covering only written lanes; state -> DRAIN.
REQ-019 dout_valid SHALL rise the cycle after a buffer becomes full (1-cycle latency); full buffers are emitted oldest first.
REQ-020 dout, dout_lane_en, dout_addr SHALL stay stable while dout_valid && !dout_ready; transfer occurs on dout_valid && dout_ready, freeing that buffer that cycle.
REQ-021 dout_addr SHALL be base_addr + words emitted, wrapping modulo 2^ADDR_WIDTH.
REQ-022 Full-word dout_lane_en SHALL be all ones; unwritten lanes of a partial word SHALL read 0.
REQ-023 A buffer freed and refilled in the same cycle SHALL be handled without loss.
REQ-024 DRAIN->DONE after the last word transfers; DONE SHALL pulse done for one cycle then go to IDLE.

Reset
REQ-025 On res high, asynchronously: state IDLE; dout, dout_lane_en, dout_addr, counters, pointers, full flags = 0; dout_valid, in_ready, done, overflow = 0.
REQ-026 Reset mid-job SHALL abandon the job; no word is emitted after res deasserts until a new start.

Structure
REQ-027 State enum, LANES and result width 16 SHALL live in the shared pooling package used by the pooling filter.
REQ-028 One sub-module pool_word_buffer (single buffer: lane write, full flag, lane mask) SHALL be instantiated twice.

Verification
REQ-029 total_results=32, base_addr=4, all three units valid every cycle, dout_ready=1 -> one word at dout_addr 4, lanes 0..31 = results in arrival order, lane_en all ones, done pulses.
REQ-030 total_results=7, single unit valid -> one word, lane_en = 0x0000007F, lanes 7..31 = 0, done.
REQ-031 total_results=96, dout_ready=0 for 40 cycles -> in_ready drops once both buffers are full, dout held stable, no loss after release; addresses base, +1, +2.
REQ-032 din_valid=3'b111 while in_ready=0 -> overflow set and stays set until next start.
REQ-033 base_addr=31, total_results=64 -> dout_addr 31 then 0.
REQ-034 res asserted mid-PACK -> all outputs 0 immediately; no dout_valid until new start.
